// File: rtl/snn_mem_pkg.sv
// rtl/snn_mem_pkg.sv - shared widths, FSM states and saturating adder for the weight-memory client
package snn_mem_pkg;

   localparam int ADDR_W = 4;
   localparam int DW     = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_WB_REQ,
      ST_WB_WAIT,
      ST_RESP
   } state_t;

   // Sum in DW+1 bits; disagreeing top bits mean overflow, the top bit gives its direction.
   function automatic logic [DW-1:0] sat_add_s(input logic [DW-1:0] old_w,
                                                input logic [DW-1:0] delta);
      logic [DW:0] sum;
      sum = {old_w[DW-1], old_w} + {delta[DW-1], delta};
      if (sum[DW] != sum[DW-1])
         return sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      return sum[DW-1:0];
   endfunction

endpackage

// File: rtl/weight_rmw_client_if.sv
// rtl/weight_rmw_client_if.sv - weight-memory arbiter port: read and writeback channels
interface weight_rmw_client_if
   import snn_mem_pkg::*;
();

   logic              w_req;
   logic [ADDR_W-1:0] w_addr;
   logic              w_valid;
   logic [DW-1:0]     w_data;
   logic              wb_req;
   logic [ADDR_W-1:0] wb_addr;
   logic [DW-1:0]     wb_data;
   logic              wb_ack;

   modport master (
      output w_req, w_addr, wb_req, wb_addr, wb_data,
      input  w_valid, w_data, wb_ack
   );

   modport slave (
      input  w_req, w_addr, wb_req, wb_addr, wb_data,
      output w_valid, w_data, wb_ack
   );

endinterface

// File: rtl/weight_rmw_client.sv
// rtl/weight_rmw_client.sv - single-outstanding weight fetch / saturating read-modify-write engine
module weight_rmw_client
   import snn_mem_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_cmd_valid,
   output logic                 o_cmd_ready,
   input  logic                 i_cmd_rmw,
   input  logic [ADDR_W-1:0]    i_cmd_addr,
   input  logic [DW-1:0]        i_cmd_delta,
   output logic                 o_rsp_valid,
   output logic [DW-1:0]        o_rsp_data,
   output logic                 o_rsp_err,
   weight_rmw_client_if.master  mem_if
);

   localparam int              CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t             r_state;
   logic               r_rmw;
   logic [DW-1:0]      r_delta;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_cmd_ready;
   logic               r_rsp_valid;
   logic [DW-1:0]      r_rsp_data;
   logic               r_rsp_err;
   logic               r_w_req;
   logic [ADDR_W-1:0]  r_w_addr;
   logic               r_wb_req;
   logic [ADDR_W-1:0]  r_wb_addr;
   logic [DW-1:0]      r_wb_data;

   assign o_cmd_ready    = r_cmd_ready;
   assign o_rsp_valid    = r_rsp_valid;
   assign o_rsp_data     = r_rsp_data;
   assign o_rsp_err      = r_rsp_err;
   assign mem_if.w_req   = r_w_req;
   assign mem_if.w_addr  = r_w_addr;
   assign mem_if.wb_req  = r_wb_req;
   assign mem_if.wb_addr = r_wb_addr;
   assign mem_if.wb_data = r_wb_data;

   // Request and response strobes are set on the transition into their state so they are registered pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_rmw       <= 1'b0;
         r_delta     <= '0;
         r_cnt       <= '0;
         r_cmd_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
         r_w_req     <= 1'b0;
         r_w_addr    <= '0;
         r_wb_req    <= 1'b0;
         r_wb_addr   <= '0;
         r_wb_data   <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         r_w_req     <= 1'b0;
         r_wb_req    <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_cmd_valid) begin
                  r_rmw       <= i_cmd_rmw;
                  r_delta     <= i_cmd_delta;
                  r_w_addr    <= i_cmd_addr;
                  r_w_req     <= 1'b1;
                  r_cmd_ready <= 1'b0;
                  r_state     <= ST_RD_REQ;
               end
            end
            ST_RD_REQ: begin
               r_cnt   <= '0;
               r_state <= ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
               if (mem_if.w_valid) begin
                  if (!r_rmw || r_delta == '0) begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_data  <= mem_if.w_data;
                     r_rsp_err   <= 1'b0;
                     r_state     <= ST_RESP;
                  end else begin
                     r_wb_req  <= 1'b1;
                     r_wb_addr <= r_w_addr;
                     r_wb_data <= sat_add_s(mem_if.w_data, r_delta);
                     r_state   <= ST_WB_REQ;
                  end
               end else if (r_cnt == CNT_LAST) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= '0;
                  r_rsp_err   <= 1'b1;
                  r_state     <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_WB_REQ: begin
               r_cnt   <= '0;
               r_state <= ST_WB_WAIT;
            end
            ST_WB_WAIT: begin
               if (mem_if.wb_ack) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= r_wb_data;
                  r_rsp_err   <= 1'b0;
                  r_state     <= ST_RESP;
               end else if (r_cnt == CNT_LAST) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= '0;
                  r_rsp_err   <= 1'b1;
                  r_state     <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_RESP: begin
               r_cmd_ready <= 1'b1;
               r_state     <= ST_IDLE;
            end
            default: begin
               r_cmd_ready <= 1'b1;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_weight_rmw_client.sv
// tb/tb_weight_rmw_client.sv - table-driven scoreboard bench for weight_rmw_client with an arbiter model
module tb_weight_rmw_client;
   import snn_mem_pkg::*;

   localparam int TIMEOUT = 15;

   logic              clk;
   logic              rst_n;
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_rmw;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DW-1:0]     cmd_delta;
   logic              rsp_valid;
   logic [DW-1:0]     rsp_data;
   logic              rsp_err;

   weight_rmw_client_if mem_if ();

   weight_rmw_client #(.TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_cmd_valid (cmd_valid),
      .o_cmd_ready (cmd_ready),
      .i_cmd_rmw   (cmd_rmw),
      .i_cmd_addr  (cmd_addr),
      .i_cmd_delta (cmd_delta),
      .o_rsp_valid (rsp_valid),
      .o_rsp_data  (rsp_data),
      .o_rsp_err   (rsp_err),
      .mem_if      (mem_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Arbiter model: answers two cycles after seeing a request, only in phase 1.
   logic [DW-1:0]     mem [16];
   logic              phase;
   logic              rd_p0, rd_p1, wb_p0, wb_p1;
   logic [ADDR_W-1:0] rd_a0, rd_a1, wb_a0, wb_a1;
   logic [DW-1:0]     wb_d0, wb_d1;

   initial begin
      mem_if.w_valid = 1'b0;
      mem_if.w_data  = '0;
      mem_if.wb_ack  = 1'b0;
      rd_p0 = 0; rd_p1 = 0; wb_p0 = 0; wb_p1 = 0;
      rd_a0 = 0; rd_a1 = 0; wb_a0 = 0; wb_a1 = 0; wb_d0 = 0; wb_d1 = 0;
   end

   always @(negedge clk) begin
      mem_if.w_valid = rd_p1;
      mem_if.w_data  = rd_p1 ? mem[rd_a1] : '0;
      mem_if.wb_ack  = wb_p1;
      if (wb_p1) mem[wb_a1] = wb_d1;
      rd_p1 = rd_p0; rd_a1 = rd_a0;
      wb_p1 = wb_p0; wb_a1 = wb_a0; wb_d1 = wb_d0;
      rd_p0 = mem_if.w_req && phase;
      rd_a0 = mem_if.w_addr;
      wb_p0 = mem_if.wb_req && phase;
      wb_a0 = mem_if.wb_addr;
      wb_d0 = mem_if.wb_data;
   end

   typedef struct {
      int cyc;
      int data;
      int err;
   } exp_t;
   exp_t exp_q[$];

   int stray = 0;
   int both_req = 0;
   int wreq_cnt, wreq_cyc, wreq_addr;
   int wb_cnt, wb_cyc, wb_addr_s, wb_data_s;

   always @(negedge clk) begin
      if (mem_if.w_req && mem_if.wb_req) both_req++;
      if (mem_if.w_req) begin
         wreq_cnt++; wreq_cyc = cyc; wreq_addr = int'(mem_if.w_addr);
      end
      if (mem_if.wb_req) begin
         wb_cnt++; wb_cyc = cyc; wb_addr_s = int'(mem_if.wb_addr); wb_data_s = int'(mem_if.wb_data);
      end
      if (rsp_valid) begin
         if (exp_q.size() == 0) begin
            stray++;
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rsp_cycle", cyc, e.cyc);
            chk("rsp_data", int'(rsp_data), e.data);
            chk("rsp_err", int'(rsp_err), e.err);
         end
      end
   end

   typedef struct {
      int rmw;
      int addr;
      int delta;
      int init;
      int exp_data;
      int exp_wb;
   } vec_t;

   int c0;

   task automatic issue(input int rmw, input int addr, input int delta);
      @(negedge clk);
      wreq_cnt = 0; wb_cnt = 0; wreq_cyc = -1; wb_cyc = -1;
      cmd_valid = 1'b1;
      cmd_rmw   = rmw[0];
      cmd_addr  = ADDR_W'(addr);
      cmd_delta = DW'(delta);
      c0 = cyc;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
         @(negedge clk);
         #2;
      end
      if (exp_q.size() != 0) begin
         chk("rsp_timeout", 0, 1);
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   vec_t vecs[$];

   initial begin
      exp_t e;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      vecs = '{
         '{0, 3, 8'h00, 8'h10, 8'h10, 0},
         '{1, 5, 8'h05, 8'h20, 8'h25, 1},
         '{1, 7, 8'h05, 8'h7E, 8'h7F, 1},
         '{1, 8, 8'hF0, 8'h82, 8'h80, 1},
         '{1, 9, 8'h00, 8'h33, 8'h33, 0},
         '{1, 2, 8'hFF, 8'h80, 8'h80, 1},
         '{1, 4, 8'hF0, 8'h10, 8'h00, 1},
         '{0, 6, 8'h07, 8'h55, 8'h55, 0}
      };
      phase = 1'b1;
      cmd_valid = 1'b0; cmd_rmw = 1'b0; cmd_addr = '0; cmd_delta = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_cmd_ready", int'(cmd_ready), 1);
      chk("reset_rsp_valid", int'(rsp_valid), 0);
      chk("reset_w_req", int'(mem_if.w_req), 0);
      chk("reset_wb_req", int'(mem_if.wb_req), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[k]) begin
         mem[vecs[k].addr] = DW'(vecs[k].init);
         e.cyc  = 0;
         e.data = vecs[k].exp_data;
         e.err  = 0;
         issue(vecs[k].rmw, vecs[k].addr, vecs[k].delta);
         e.cyc = c0 + (vecs[k].exp_wb != 0 ? 7 : 4);
         exp_q.push_back(e);
         wait_done();
         chk("w_req_count", wreq_cnt, 1);
         chk("w_req_cycle", wreq_cyc, c0 + 1);
         chk("w_addr", wreq_addr, vecs[k].addr);
         chk("wb_req_count", wb_cnt, vecs[k].exp_wb);
         if (vecs[k].exp_wb != 0) begin
            chk("wb_req_cycle", wb_cyc, c0 + 4);
            chk("wb_addr", wb_addr_s, vecs[k].addr);
            chk("wb_data", wb_data_s, vecs[k].exp_data);
         end
         chk("mem_after", int'(mem[vecs[k].addr]), vecs[k].exp_data);
         chk("cmd_ready_idle", int'(cmd_ready), 1);
      end

      // Arbiter silent: read must time out after TIMEOUT wait cycles.
      phase = 1'b0;
      mem[1] = 8'h44;
      issue(0, 1, 0);
      e.cyc = c0 + 2 + TIMEOUT; e.data = 0; e.err = 1;
      exp_q.push_back(e);
      wait_done();
      phase = 1'b1;
      issue(0, 1, 0);
      e.cyc = c0 + 4; e.data = 8'h44; e.err = 0;
      exp_q.push_back(e);
      wait_done();

      // Reset while waiting for wb_ack; the late ack must not produce a response.
      mem[10] = 8'h01;
      issue(1, 10, 1);
      for (int i = 0; i < 20 && cyc < c0 + 5; i++) @(negedge clk);
      chk("pre_reset_wb_req_cycle", wb_cyc, c0 + 4);
      rst_n = 1'b0;
      #1;
      chk("mid_reset_cmd_ready", int'(cmd_ready), 1);
      chk("mid_reset_rsp_valid", int'(rsp_valid), 0);
      chk("mid_reset_rsp_data", int'(rsp_data), 0);
      chk("mid_reset_rsp_err", int'(rsp_err), 0);
      chk("mid_reset_w_req", int'(mem_if.w_req), 0);
      chk("mid_reset_w_addr", int'(mem_if.w_addr), 0);
      chk("mid_reset_wb_req", int'(mem_if.wb_req), 0);
      chk("mid_reset_wb_addr", int'(mem_if.wb_addr), 0);
      chk("mid_reset_wb_data", int'(mem_if.wb_data), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("stray_rsp_after_reset", stray, 0);
      chk("cmd_ready_after_reset", int'(cmd_ready), 1);

      issue(0, 10, 0);
      e.cyc = c0 + 4; e.data = 8'h02; e.err = 0;
      exp_q.push_back(e);
      wait_done();

      chk("w_req_wb_req_overlap", both_req, 0);
      chk("stray_rsp_total", stray, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
